// File: rtl/omsp_sm_id_manager.sv
// omsp_sm_id_manager: protected-module slot allocation, monotonic ID assignment, key-store scrub sequencing and current/previous ID tracking
module omsp_sm_id_manager #(
   parameter  int NB_SLOTS  = 4,
   parameter  int SLOT_W    = 2,
   parameter  int ID_W      = 16,
   parameter  int IRQ_BITS  = 4,
   parameter  int KEY_WORDS = 4,
   localparam int IDX_W     = $clog2(KEY_WORDS + 1)
) (
   input  logic                     mclk,
   input  logic                     puc_rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_op,
   input  logic [SLOT_W-1:0]        req_slot,
   output logic                     rsp_valid,
   output logic                     rsp_ok,
   output logic [SLOT_W-1:0]        rsp_slot,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     scrub_we,
   output logic [SLOT_W-1:0]        scrub_slot,
   output logic [IDX_W-1:0]         scrub_idx,
   output logic [NB_SLOTS-1:0]      slot_enabled,
   output logic [NB_SLOTS*ID_W-1:0] slot_id_flat,
   input  logic [NB_SLOTS-1:0]      slot_executing,
   input  logic                     handling_irq,
   input  logic [IRQ_BITS-1:0]      irq_num,
   output logic [ID_W-1:0]          current_id,
   output logic [ID_W-1:0]          prev_id,
   output logic                     id_exhausted,
   output logic                     violation
);

   localparam int                ID_MAX_I = (1 << ID_W) - (1 << IRQ_BITS) - 1;
   localparam logic [ID_W-1:0]   ID_MAX   = ID_MAX_I[ID_W-1:0];
   localparam logic [ID_W-1:0]   IRQ_BASE = ID_MAX + ID_W'(1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(KEY_WORDS - 1);
   localparam logic [IDX_W-1:0]  DONE_IDX = IDX_W'(KEY_WORDS);

   typedef enum logic {IDLE, SCRUB} state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    cnt;
   logic [SLOT_W-1:0]   sc_slot;
   logic [ID_W-1:0]     slot_id [NB_SLOTS];
   logic [ID_W-1:0]     next_id;
   logic [ID_W-1:0]     cur_q;
   logic [ID_W-1:0]     sel_id;
   logic [SLOT_W-1:0]   free_slot;
   logic                has_free;
   logic                acc;
   logic                free_en;
   logic                one_live;
   logic                exec_conflict;
   logic [NB_SLOTS-1:0] exec_live;

   assign acc           = req_valid & req_ready;
   assign free_en       = (int'(req_slot) < NB_SLOTS) && slot_enabled[req_slot];
   assign exec_live     = slot_executing & slot_enabled;
   assign one_live      = (exec_live != '0) && ((exec_live & (exec_live - NB_SLOTS'(1))) == '0);
   assign exec_conflict = ((slot_executing & (slot_executing - NB_SLOTS'(1))) != '0) |
                          (|(slot_executing & ~slot_enabled));
   assign current_id    = handling_irq ? IRQ_BASE + ID_W'(irq_num) : (one_live ? sel_id : '0);
   assign violation     = exec_conflict | id_exhausted;

   // Lowest-index slot that is neither live nor dying
   always_comb begin
      has_free  = 1'b0;
      free_slot = '0;
      for (int i = NB_SLOTS - 1; i >= 0; i--)
         if (!slot_enabled[i]) begin
            has_free  = 1'b1;
            free_slot = SLOT_W'(i);
         end
   end

   // ID of the single live executing slot, plus the flattened per-slot ID view
   always_comb begin
      sel_id       = '0;
      slot_id_flat = '0;
      for (int i = 0; i < NB_SLOTS; i++) begin
         if (exec_live[i]) sel_id = sel_id | slot_id[i];
         slot_id_flat[i*ID_W +: ID_W] = slot_id[i];
      end
   end

   // FSM state register
   always_ff @(posedge mclk or negedge puc_rst_n)
      if (!puc_rst_n) state <= IDLE;
      else            state <= state_nxt;

   // FSM next state: enter SCRUB on a free of a live slot, leave after the completion cycle
   always_comb begin
      state_nxt = state;
      if (state == IDLE && acc && req_op && free_en) state_nxt = SCRUB;
      else if (state == SCRUB && cnt == DONE_IDX)    state_nxt = IDLE;
   end

   // FSM outputs: handshake ready and key-store zero-write strobe
   always_comb begin
      req_ready  = (state == IDLE);
      scrub_we   = (state == SCRUB) && (cnt < DONE_IDX);
      scrub_slot = scrub_we ? sc_slot : '0;
      scrub_idx  = scrub_we ? cnt : '0;
   end

   // Slot table, ID counter, response pulse and previous-ID tracking
   always_ff @(posedge mclk or negedge puc_rst_n)
      if (!puc_rst_n) begin
         slot_enabled <= '0;
         for (int i = 0; i < NB_SLOTS; i++) slot_id[i] <= '0;
         next_id      <= ID_W'(1);
         id_exhausted <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_ok       <= 1'b0;
         rsp_slot     <= '0;
         rsp_id       <= '0;
         sc_slot      <= '0;
         cnt          <= '0;
         cur_q        <= '0;
         prev_id      <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_ok    <= 1'b0;
         rsp_slot  <= '0;
         rsp_id    <= '0;
         cur_q     <= current_id;
         if (current_id != cur_q) prev_id <= cur_q;
         if (acc && !req_op) begin
            rsp_valid <= 1'b1;
            if (next_id > ID_MAX) id_exhausted <= 1'b1;
            if (has_free && next_id <= ID_MAX) begin
               rsp_ok                  <= 1'b1;
               rsp_slot                <= free_slot;
               rsp_id                  <= next_id;
               slot_enabled[free_slot] <= 1'b1;
               slot_id[free_slot]      <= next_id;
               next_id                 <= next_id + ID_W'(1);
            end
         end
         if (acc && req_op) begin
            if (free_en) begin
               sc_slot <= req_slot;
               cnt     <= '0;
            end else begin
               rsp_valid <= 1'b1;
               rsp_slot  <= req_slot;
            end
         end
         if (state == SCRUB && cnt != DONE_IDX) begin
            cnt <= cnt + IDX_W'(1);
            if (cnt == LAST_IDX) begin
               rsp_valid             <= 1'b1;
               rsp_ok                <= 1'b1;
               rsp_slot              <= sc_slot;
               rsp_id                <= slot_id[sc_slot];
               slot_enabled[sc_slot] <= 1'b0;
               slot_id[sc_slot]      <= '0;
            end
         end
      end

endmodule

// File: tb/tb_omsp_sm_id_manager.sv
// tb_omsp_sm_id_manager: directed and randomized checks of omsp_sm_id_manager against a slot-table reference model
module tb_omsp_sm_id_manager;

   localparam int NS = 4, SW = 2, IW = 8, IB = 4, KW = 4;
   localparam int XW = $clog2(KW + 1);
   localparam int ID_MAX = (1 << IW) - (1 << IB) - 1;

   logic             mclk = 1'b0;
   logic             puc_rst_n = 1'b0;
   logic             req_valid = 1'b0, req_op = 1'b0;
   logic [SW-1:0]    req_slot = '0;
   logic             req_ready, rsp_valid, rsp_ok, scrub_we, id_exhausted, violation;
   logic [SW-1:0]    rsp_slot, scrub_slot;
   logic [IW-1:0]    rsp_id, current_id, prev_id;
   logic [XW-1:0]    scrub_idx;
   logic [NS-1:0]    slot_enabled;
   logic [NS-1:0]    slot_executing = '0;
   logic [NS*IW-1:0] slot_id_flat;
   logic             handling_irq = 1'b0;
   logic [IB-1:0]    irq_num = '0;

   int checks = 0;
   int failures = 0;

   bit m_en [NS];
   int m_id [NS];
   int m_next = 1;
   bit m_exh = 0;

   logic [IW-1:0] last_cur = '0, exp_prev = '0;

   omsp_sm_id_manager #(.NB_SLOTS(NS), .SLOT_W(SW), .ID_W(IW), .IRQ_BITS(IB), .KEY_WORDS(KW)) dut (
      .mclk(mclk), .puc_rst_n(puc_rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_slot(req_slot),
      .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_slot(rsp_slot), .rsp_id(rsp_id),
      .scrub_we(scrub_we), .scrub_slot(scrub_slot), .scrub_idx(scrub_idx),
      .slot_enabled(slot_enabled), .slot_id_flat(slot_id_flat),
      .slot_executing(slot_executing), .handling_irq(handling_irq), .irq_num(irq_num),
      .current_id(current_id), .prev_id(prev_id),
      .id_exhausted(id_exhausted), .violation(violation)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NS-1:0] exp_en();
      logic [NS-1:0] e = '0;
      for (int i = 0; i < NS; i++) e[i] = m_en[i];
      return e;
   endfunction

   function automatic logic [NS*IW-1:0] exp_flat();
      logic [NS*IW-1:0] f = '0;
      for (int i = 0; i < NS; i++) f[i*IW +: IW] = IW'(m_id[i]);
      return f;
   endfunction

   function automatic int lowest_enabled();
      for (int i = 0; i < NS; i++) if (m_en[i]) return i;
      return -1;
   endfunction

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin m_en[i] = 0; m_id[i] = 0; end
      m_next = 1;
      m_exh = 0;
   endtask

   task automatic check_tables(input string tag);
      chk({tag, "_enabled"}, 64'(slot_enabled), 64'(exp_en()));
      chk({tag, "_flat"}, 64'(slot_id_flat), 64'(exp_flat()));
   endtask

   // prev_id is the value current_id held just before its most recent change, lagging one edge
   always @(negedge mclk)
      if (!puc_rst_n) begin
         last_cur <= '0;
         exp_prev <= '0;
      end else begin
         chk("prev_id", 64'(prev_id), 64'(exp_prev));
         if (current_id !== last_cur) exp_prev <= last_cur;
         last_cur <= current_id;
      end

   task automatic do_req(input bit op, input int slot);
      int tgt;
      bit ok;
      chk("req_ready_before", 64'(req_ready), 64'(1));
      req_valid = 1'b1;
      req_op    = op;
      req_slot  = SW'(slot);
      step();
      req_valid = 1'b0;
      if (!op) begin
         tgt = -1;
         for (int i = NS - 1; i >= 0; i--) if (!m_en[i]) tgt = i;
         ok = (tgt >= 0) && (m_next <= ID_MAX);
         if (m_next > ID_MAX) m_exh = 1;
         chk("alloc_rsp_valid", 64'(rsp_valid), 64'(1));
         chk("alloc_rsp_ok", 64'(rsp_ok), 64'(ok));
         chk("alloc_rsp_slot", 64'(rsp_slot), ok ? 64'(tgt) : 64'(0));
         chk("alloc_rsp_id", 64'(rsp_id), ok ? 64'(m_next) : 64'(0));
         if (ok) begin
            m_en[tgt] = 1;
            m_id[tgt] = m_next;
            m_next++;
         end
         check_tables("alloc");
         chk("alloc_exhausted", 64'(id_exhausted), 64'(m_exh));
         chk("alloc_ready", 64'(req_ready), 64'(1));
         chk("alloc_no_scrub", 64'(scrub_we), 64'(0));
      end else if (!m_en[slot]) begin
         chk("free_dis_rsp_valid", 64'(rsp_valid), 64'(1));
         chk("free_dis_rsp_ok", 64'(rsp_ok), 64'(0));
         chk("free_dis_rsp_slot", 64'(rsp_slot), 64'(slot));
         chk("free_dis_rsp_id", 64'(rsp_id), 64'(0));
         chk("free_dis_no_scrub", 64'(scrub_we), 64'(0));
         chk("free_dis_ready", 64'(req_ready), 64'(1));
      end else begin
         for (int k = 0; k < KW; k++) begin
            chk("scrub_we", 64'(scrub_we), 64'(1));
            chk("scrub_idx", 64'(scrub_idx), 64'(k));
            chk("scrub_slot", 64'(scrub_slot), 64'(slot));
            chk("scrub_ready_low", 64'(req_ready), 64'(0));
            chk("scrub_no_rsp", 64'(rsp_valid), 64'(0));
            check_tables("scrub_dying");
            step();
         end
         chk("free_rsp_valid", 64'(rsp_valid), 64'(1));
         chk("free_rsp_ok", 64'(rsp_ok), 64'(1));
         chk("free_rsp_slot", 64'(rsp_slot), 64'(slot));
         chk("free_rsp_id", 64'(rsp_id), 64'(m_id[slot]));
         chk("free_done_no_scrub", 64'(scrub_we), 64'(0));
         chk("free_done_ready_low", 64'(req_ready), 64'(0));
         m_en[slot] = 0;
         m_id[slot] = 0;
         check_tables("free_done");
         step();
         chk("free_ready_back", 64'(req_ready), 64'(1));
         chk("free_rsp_pulse", 64'(rsp_valid), 64'(0));
      end
   endtask

   task automatic exec_chk(input logic [NS-1:0] se, input bit irq, input int num);
      logic [NS-1:0] en, lv;
      int e_cur;
      bit conflict;
      slot_executing = se;
      handling_irq   = irq;
      irq_num        = IB'(num);
      #1;
      en = exp_en();
      lv = se & en;
      e_cur = 0;
      if (irq) e_cur = (1 << IW) - (1 << IB) + num;
      else if ($countones(lv) == 1)
         for (int i = 0; i < NS; i++) if (lv[i]) e_cur = m_id[i];
      conflict = ($countones(se) > 1) || ((se & ~en) != '0);
      chk("current_id", 64'(current_id), 64'(e_cur));
      chk("violation", 64'(violation), 64'(conflict || m_exh));
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_ready"}, 64'(req_ready), 64'(1));
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, "_rsp_ok"}, 64'(rsp_ok), 64'(0));
      chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
      chk({tag, "_scrub_we"}, 64'(scrub_we), 64'(0));
      chk({tag, "_scrub_idx"}, 64'(scrub_idx), 64'(0));
      chk({tag, "_enabled"}, 64'(slot_enabled), 64'(0));
      chk({tag, "_flat"}, 64'(slot_id_flat), 64'(0));
      chk({tag, "_prev"}, 64'(prev_id), 64'(0));
      chk({tag, "_exhausted"}, 64'(id_exhausted), 64'(0));
      chk({tag, "_violation"}, 64'(violation), 64'(0));
      chk({tag, "_current"}, 64'(current_id), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      model_reset();
      repeat (3) @(posedge mclk);
      #1;
      reset_checks("reset");
      puc_rst_n = 1'b1;
      step();
      for (int i = 0; i < NS + 1; i++) do_req(0, 0);
      chk("full_next_id_kept", 64'(m_next), 64'(5));
      do_req(1, 1);
      do_req(0, 0);
      chk("realloc_slot1_id5", 64'(slot_id_flat[1*IW +: IW]), 64'(5));
      exec_chk(4'b0000, 0, 0);
      step();
      exec_chk(4'b0100, 0, 0);
      chk("slot2_id3", 64'(current_id), 64'(3));
      step();
      exec_chk(4'b0000, 1, 5);
      step();
      chk("prev_after_irq", 64'(prev_id), 64'(3));
      exec_chk(4'b0011, 0, 0);
      step();
      exec_chk(4'b0000, 0, 0);
      do_req(1, 2);
      do_req(1, 2);
      exec_chk(4'b0100, 0, 0);
      step();
      exec_chk(4'b0000, 0, 0);
      for (int n = 0; n < 40; n++) begin
         do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)));
         exec_chk(NS'($urandom_range(0, (1 << NS) - 1)), 1'($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, (1 << IB) - 1)));
         step();
      end
      exec_chk(4'b0000, 0, 0);
      while (m_next <= ID_MAX) begin
         s = -1;
         for (int i = NS - 1; i >= 0; i--) if (!m_en[i]) s = i;
         if (s >= 0) do_req(0, 0);
         else do_req(1, lowest_enabled());
      end
      chk("next_id_at_limit", 64'(m_next), 64'(ID_MAX + 1));
      if (lowest_enabled() < 0) do_req(0, 0);
      if (lowest_enabled() >= 0 && lowest_enabled() < NS) begin
         s = -1;
         for (int i = NS - 1; i >= 0; i--) if (!m_en[i]) s = i;
         if (s < 0) do_req(1, lowest_enabled());
      end
      do_req(0, 0);
      chk("exhausted_set", 64'(id_exhausted), 64'(1));
      exec_chk(4'b0000, 0, 0);
      step();
      step();
      chk("exhausted_sticky", 64'(id_exhausted), 64'(1));
      chk("exhausted_violation", 64'(violation), 64'(1));
      s = lowest_enabled();
      req_valid = 1'b1;
      req_op    = 1'b1;
      req_slot  = SW'(s);
      step();
      req_valid = 1'b0;
      step();
      chk("mid_scrub_we", 64'(scrub_we), 64'(1));
      chk("mid_scrub_idx", 64'(scrub_idx), 64'(1));
      puc_rst_n = 1'b0;
      #1;
      model_reset();
      reset_checks("mid_scrub_reset");
      step();
      puc_rst_n = 1'b1;
      step();
      reset_checks("post_reset");
      do_req(0, 0);
      chk("post_reset_first_id", 64'(slot_id_flat[0 +: IW]), 64'(1));
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
